// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one block-RAM port among N_REQ requesters, round-robin, with flush/drain FSM.
// Define RAM_ARB_FIXED_PRIORITY_EN to replace round-robin with lowest-index-wins priority.
module ram_port_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int BE_W    = 4,
  parameter int LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ-1:0]          req_wren,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic [N_REQ*BE_W-1:0]     req_be,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  input  logic                      flush,
  output logic                      flush_done,
  output logic                      ram_clken,
  output logic [ADDR_W-1:0]         ram_address,
  output logic                      ram_wren,
  output logic [DATA_W-1:0]         ram_data,
  output logic [BE_W-1:0]           ram_byteena,
  input  logic [DATA_W-1:0]         ram_q
);
  localparam int PTR_W = $clog2(N_REQ);
  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
  state_t r_state, w_next;
  logic [PTR_W-1:0] w_gid;
  logic w_any, w_xfer, w_rd, w_rsp;
  logic [LATENCY-1:0] r_pv;
  logic [PTR_W-1:0] r_pid [LATENCY];
  int w_base;
`ifdef RAM_ARB_FIXED_PRIORITY_EN
  assign w_base = 0;
`else
  logic [PTR_W-1:0] r_ptr;
  assign w_base = int'(r_ptr) + 1;
  always_ff @(posedge clk)
    if (reset) r_ptr <= PTR_W'(N_REQ-1);
    else if (w_xfer) r_ptr <= w_gid;
`endif
  // Scan from the far end so the nearest valid requester after the pointer wins.
  always_comb begin
    w_gid = '0;
    w_any = 1'b0;
    for (int k = N_REQ-1; k >= 0; k--)
      if (req_valid[(w_base+k) % N_REQ]) begin
        w_any = 1'b1;
        w_gid = PTR_W'((w_base+k) % N_REQ);
      end
  end
  assign w_xfer      = w_any && r_state == RUN && !flush && !reset;
  assign w_rd        = w_xfer && !req_wren[w_gid];
  assign req_ready   = w_xfer ? N_REQ'(1) << w_gid : '0;
  assign ram_clken   = !reset;
  assign ram_address = w_xfer ? req_addr[w_gid*ADDR_W +: ADDR_W] : '0;
  assign ram_wren    = w_xfer && req_wren[w_gid];
  assign ram_data    = w_xfer ? req_data[w_gid*DATA_W +: DATA_W] : '0;
  assign ram_byteena = w_xfer ? req_be[w_gid*BE_W +: BE_W] : '0;
  // Read tracker mirrors the RAM latency so ram_q lines up with the owning id.
  always_ff @(posedge clk)
    if (reset) r_pv <= '0;
    else begin
      r_pv[0] <= w_rd;
      for (int s = 1; s < LATENCY; s++) r_pv[s] <= r_pv[s-1];
    end
  always_ff @(posedge clk) begin
    r_pid[0] <= w_gid;
    for (int s = 1; s < LATENCY; s++) r_pid[s] <= r_pid[s-1];
  end
  assign w_rsp     = r_pv[LATENCY-1] && !reset;
  assign rsp_valid = w_rsp ? N_REQ'(1) << r_pid[LATENCY-1] : '0;
  assign rsp_data  = w_rsp ? ram_q : '0;
  always_ff @(posedge clk)
    r_state <= reset ? RUN : w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      RUN:     w_next = flush ? DRAIN : RUN;
      DRAIN:   w_next = !flush ? RUN : (r_pv == '0 ? DONE : DRAIN);
      DONE:    w_next = flush ? DONE : RUN;
      default: w_next = RUN;
    endcase
  end
  assign flush_done = r_state == DONE && flush && !reset;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: vector table plus cycle-level scoreboard for ram_port_arbiter on a behavioural RAM.
module tb_ram_port_arbiter;
  localparam int N = 4, AW = 8, DW = 32, BW = 4, LAT = 3;
`ifdef RAM_ARB_FIXED_PRIORITY_EN
  localparam bit FP = 1'b1;
`else
  localparam bit FP = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, flush = 1'b0;
  logic [N-1:0] req_valid = '0, req_wren = '0, req_ready, rsp_valid, gm;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N*BW-1:0] req_be = '0;
  logic [DW-1:0] rsp_data, ram_data, ram_q;
  logic flush_done, ram_clken, ram_wren, done;
  logic [AW-1:0] ram_address, ga;
  logic [BW-1:0] ram_byteena;
  int n_tests = 0, n_fail = 0, cyc = 0, nrsp;

  ram_port_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .BE_W(BW), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_wren(req_wren),
    .req_addr(req_addr), .req_data(req_data), .req_be(req_be), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .flush(flush), .flush_done(flush_done), .ram_clken(ram_clken),
    .ram_address(ram_address), .ram_wren(ram_wren), .ram_data(ram_data),
    .ram_byteena(ram_byteena), .ram_q(ram_q));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Behavioural RAM: old data on read, byte-enabled write, LAT-cycle read pipeline.
  logic [DW-1:0] mem [256], m_mem [256], qp [LAT];
  always @(posedge clk)
    if (ram_clken) begin
      qp[0] <= mem[ram_address];
      for (int s = 1; s < LAT; s++) qp[s] <= qp[s-1];
      if (ram_wren)
        for (int b = 0; b < BW; b++)
          if (ram_byteena[b]) mem[ram_address][8*b +: 8] = ram_data[8*b +: 8];
    end
  assign ram_q = qp[LAT-1];

  // Reference arbiter/flush model and response scoreboard.
  typedef enum {M_RUN, M_DRAIN, M_DONE} mst_t;
  typedef struct {int due; int id; logic [DW-1:0] data;} exp_t;
  exp_t sbq[$];
  exp_t e;
  mst_t m_st = M_RUN;
  int m_ptr = N-1, g, idx;
  logic m_empty;
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      chk("rst_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_flush_done", flush_done, 0);
      chk("rst_clken", ram_clken, 0);
      chk("rst_wren", ram_wren, 0);
      chk("rst_addr", ram_address, 0);
      chk("rst_be", ram_byteena, 0);
      m_ptr = N-1;
      sbq.delete();
      m_st = M_RUN;
    end else begin
      m_empty = sbq.size() == 0;
      g = -1;
      if (m_st == M_RUN && !flush)
        for (int k = 0; k < N; k++) begin
          idx = FP ? k : (m_ptr + 1 + k) % N;
          if (g < 0 && req_valid[idx]) g = idx;
        end
      chk("ready", req_ready, g < 0 ? 0 : 1 << g);
      chk("flush_done", flush_done, m_st == M_DONE && flush);
      chk("clken", ram_clken, 1);
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        e = sbq.pop_front();
        chk("rsp_valid", rsp_valid, 1 << e.id);
        chk("rsp_data", rsp_data, e.data);
      end else begin
        chk("rsp_valid_idle", rsp_valid, 0);
        chk("rsp_data_idle", rsp_data, 0);
      end
      if (g < 0) begin
        chk("idle_wren", ram_wren, 0);
        chk("idle_be", ram_byteena, 0);
      end else begin
        ga = req_addr[g*AW +: AW];
        chk("ram_addr", ram_address, ga);
        chk("ram_wren", ram_wren, req_wren[g]);
        if (req_wren[g]) begin
          chk("ram_data", ram_data, req_data[g*DW +: DW]);
          chk("ram_be", ram_byteena, req_be[g*BW +: BW]);
          for (int b = 0; b < BW; b++)
            if (req_be[g*BW+b]) m_mem[ga][8*b +: 8] = req_data[g*DW+8*b +: 8];
        end else sbq.push_back('{cyc + LAT, g, m_mem[ga]});
        m_ptr = g;
      end
      case (m_st)
        M_RUN:   m_st = flush ? M_DRAIN : M_RUN;
        M_DRAIN: m_st = !flush ? M_RUN : (m_empty ? M_DONE : M_DRAIN);
        default: m_st = flush ? M_DONE : M_RUN;
      endcase
    end
  end

  task automatic xfer(input int id, input logic wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [BW-1:0] be);
    req_addr[id*AW +: AW] = a;
    req_data[id*DW +: DW] = d;
    req_be[id*BW +: BW] = be;
    req_wren[id] = wr;
    req_valid[id] = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (req_ready[id]) break;
      if (t == 19) chk("xfer_timeout", req_ready[id], 1);
    end
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
    req_wren[id] = 1'b0;
  endtask

  task automatic wait_rsp(input string nm, input int id, input logic [DW-1:0] exp);
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (rsp_valid[id]) break;
    end
    chk({nm, "_valid"}, rsp_valid, 1 << id);
    chk({nm, "_data"}, rsp_data, exp);
  endtask

  typedef struct {logic [N-1:0] valid; logic [N-1:0] exp_rdy;} vec_t;
  vec_t tbl[16];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {16'hCAFE, 8'h00, 8'(i)};
    mem[16] = 32'hCAFE0001;
    for (int i = 0; i < 256; i++) m_mem[i] = mem[i];
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = 8'(16 + i);
    tbl = '{
      '{4'b0000, 4'b0000}, '{4'b0000, 4'b0000},
      '{4'b1111, 4'b0001}, '{4'b1111, FP ? 4'b0001 : 4'b0010},
      '{4'b1111, FP ? 4'b0001 : 4'b0100}, '{4'b1111, FP ? 4'b0001 : 4'b1000},
      '{4'b1111, 4'b0001}, '{4'b1111, FP ? 4'b0001 : 4'b0010},
      '{4'b1111, FP ? 4'b0001 : 4'b0100}, '{4'b1111, FP ? 4'b0001 : 4'b1000},
      '{4'b0001, 4'b0001}, '{4'b0000, 4'b0000},
      '{4'b1010, 4'b0010}, '{4'b1010, FP ? 4'b0010 : 4'b1000},
      '{4'b0000, 4'b0000}, '{4'b0000, 4'b0000}};
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      req_valid = tbl[i].valid;
      @(negedge clk); #1;
      chk($sformatf("tbl%0d", i), req_ready, tbl[i].exp_rdy);
      @(posedge clk); #1;
    end
    req_valid = '0;
    repeat (5) @(posedge clk);
    #1;
    xfer(1, 1'b1, 8'h20, 32'h55AA55AA, 4'b1111);
    xfer(2, 1'b0, 8'h20, 32'h0, 4'b0000);
    wait_rsp("wr_rd", 2, 32'h55AA55AA);
    @(posedge clk); #1;
    xfer(1, 1'b1, 8'h20, 32'h000000FF, 4'b0001);
    xfer(2, 1'b0, 8'h20, 32'h0, 4'b0000);
    wait_rsp("be_rd", 2, 32'h55AA55FF);
    repeat (4) @(posedge clk);
    #1;
    req_valid = 4'b1001;
    for (int t = 0; t < 10 && req_valid != 0; t++) begin
      @(negedge clk);
      gm = req_ready;
      @(posedge clk); #1;
      req_valid = req_valid & ~gm;
    end
    chk("flush_pre_grants", req_valid, 0);
    flush = 1'b1;
    req_valid[2] = 1'b1;
    nrsp = 0;
    done = 1'b0;
    for (int t = 0; t < 12 && !done; t++) begin
      @(negedge clk);
      chk("flush_no_ready", req_ready, 0);
      if (|rsp_valid) nrsp++;
      done = flush_done;
    end
    chk("flush_done_seen", done, 1);
    chk("flush_rsp_count", nrsp, 2);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("unflush_wait", req_ready, 0);
    @(negedge clk);
    chk("unflush_grant", req_ready, 4'b0100);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (6) @(posedge clk);
    #1;
    xfer(0, 1'b0, 8'h10, 32'h0, 4'b0000);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      chk("post_rst_rsp", rsp_valid, 0);
    end
    @(posedge clk); #1;
    chk("sb_empty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
